mem7489_arb_ctrl: RTL and testbench

//  Synchronous controller/arbiter for the 16x4 7489-style RAM built from mem_celda cells.

---
 rtl/mem7489_arb_ctrl_if.sv | 47 ++++
 rtl/mem7489_arb_ctrl.sv | 140 ++++++++++++++
 tb/tb_mem7489_arb_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem7489_arb_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem7489_arb_ctrl_if
//   Signal bundle around the 7489-style RAM controller.
//   Requester side : req/we/addr/wdata for A and B, ack_a/ack_b, rdata, busy
//   Array side     : mem_addr, mem_di, mem_en, mem_wri (to the cells),
//                    mem_do_n (inverted read data back from the cells)
//   slave  : view taken by the controller
//   master : view taken by whatever drives requests and models the array
// ---------------------------------------------------------------------------
interface mem7489_arb_ctrl_if #(
    parameter int AW = 4,
    parameter int DW = 4
);
    logic          req_a;
    logic          we_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] wdata_a;
    logic          req_b;
    logic          we_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] wdata_b;
    logic          ack_a;
    logic          ack_b;
    logic [DW-1:0] rdata;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_di;
    logic          mem_en;
    logic          mem_wri;
    logic [DW-1:0] mem_do_n;

    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        input  mem_do_n,
        output ack_a, ack_b, rdata, busy,
        output mem_addr, mem_di, mem_en, mem_wri
    );

    modport master (
        output req_a, we_a, addr_a, wdata_a,
        output req_b, we_b, addr_b, wdata_b,
        output mem_do_n,
        input  ack_a, ack_b, rdata, busy,
        input  mem_addr, mem_di, mem_en, mem_wri
    );
endinterface

// File: rtl/mem7489_arb_ctrl.sv
// ---------------------------------------------------------------------------
// mem7489_arb_ctrl
//   Round-robin arbiter + strobe sequencer for a 16x4 7489-style RAM.
//   Two requesters share the array; each transfer walks
//   IDLE -> SETUP -> (WPULSE -> HOLD | RACC) -> DONE -> IDLE, holding
//   address/data steady around the level-sensitive Wri pulse.
//   Ports:
//     clk      rising-edge clock
//     reset_L  asynchronous reset, active low
//     bus      mem7489_arb_ctrl_if.slave (requesters + array strobes)
//   Every output is a flop, so mem_wri/mem_en cannot glitch and drop
//   immediately on reset.
// ---------------------------------------------------------------------------
module mem7489_arb_ctrl #(
    parameter int AW      = 4,
    parameter int DW      = 4,
    parameter int T_SETUP = 1,
    parameter int T_WP    = 2,
    parameter int T_HOLD  = 1,
    parameter int T_ACC   = 2
) (
    input logic               clk,
    input logic               reset_L,
    mem7489_arb_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, WPULSE, HOLD, RACC, DONE} state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    // phase counter reload values: a phase of N cycles counts N-1 down to 0
    localparam logic [3:0] C_SETUP = 4'(T_SETUP - 1);
    localparam logic [3:0] C_WP    = 4'(T_WP - 1);
    localparam logic [3:0] C_HOLD  = 4'(T_HOLD - 1);
    localparam logic [3:0] C_ACC   = 4'(T_ACC - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       ptr_b;    // 1: B wins a tie
    logic       win_b;    // side being served
    logic       we_q;
    logic       grant_b;
    req_t       req_sel;

    // B wins if it is the only requester, or on a tie when the pointer says B
    assign grant_b = bus.req_b && (!bus.req_a || ptr_b);

    always_comb begin
        req_sel = grant_b ? '{we: bus.we_b, addr: bus.addr_b, wdata: bus.wdata_b}
                          : '{we: bus.we_a, addr: bus.addr_a, wdata: bus.wdata_a};
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state        <= IDLE;
            cnt          <= '0;
            ptr_b        <= 1'b0;
            win_b        <= 1'b0;
            we_q         <= 1'b0;
            bus.ack_a    <= 1'b0;
            bus.ack_b    <= 1'b0;
            bus.rdata    <= '0;
            bus.busy     <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_di   <= '0;
            bus.mem_en   <= 1'b0;
            bus.mem_wri  <= 1'b0;
        end else begin
            bus.ack_a <= 1'b0;
            bus.ack_b <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_a || bus.req_b) begin
                        win_b        <= grant_b;
                        we_q         <= req_sel.we;
                        bus.mem_addr <= req_sel.addr;
                        bus.mem_di   <= req_sel.wdata;
                        bus.mem_en   <= 1'b1;
                        bus.busy     <= 1'b1;
                        cnt          <= C_SETUP;
                        state        <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (we_q) begin
                        bus.mem_wri <= 1'b1;
                        cnt         <= C_WP;
                        state       <= WPULSE;
                    end else begin
                        cnt   <= C_ACC;
                        state <= RACC;
                    end
                end
                WPULSE: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        bus.mem_wri <= 1'b0;
                        cnt         <= C_HOLD;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        bus.mem_en <= 1'b0;
                        bus.ack_a  <= !win_b;
                        bus.ack_b  <= win_b;
                        state      <= DONE;
                    end
                end
                RACC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // array returns inverted data; sample on the last access cycle
                        bus.rdata  <= ~bus.mem_do_n;
                        bus.mem_en <= 1'b0;
                        bus.ack_a  <= !win_b;
                        bus.ack_b  <= win_b;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    // the pointer moves to the side just served's opposite
                    ptr_b    <= !win_b;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem7489_arb_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench: the driver computes expected acks (side, cycle, data)
// from a plain round-robin / memory model and queues them; the monitor pops
// on every ack and also checks the Wri window and idle/reset outputs.
module tb_mem7489_arb_ctrl;
    localparam int AW = 4, DW = 4;
    localparam int T_SETUP = 1, T_WP = 2, T_HOLD = 1, T_ACC = 2;
    localparam int LAT_W = 1 + T_SETUP + T_WP + T_HOLD;
    localparam int LAT_R = 1 + T_SETUP + T_ACC;
    localparam int BOUND = 60;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    typedef struct {
        bit            side;   // 0 = A, 1 = B
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;   // write data, or expected read data
        int            cyc;    // cycle number at which ack is visible
    } exp_t;

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    int   cyc = 0;

    mem7489_arb_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    mem7489_arb_ctrl #(
        .AW(AW), .DW(DW), .T_SETUP(T_SETUP), .T_WP(T_WP), .T_HOLD(T_HOLD), .T_ACC(T_ACC)
    ) dut (
        .clk    (clk),
        .reset_L(reset_L),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural 16x4 array: level-sensitive write, inverted read
    logic [DW-1:0] arr [0:15];
    always @(posedge clk) if (bus.mem_wri) arr[bus.mem_addr] <= bus.mem_di;
    assign bus.mem_do_n = ~arr[bus.mem_addr];

    // reference model state
    exp_t          q[$];
    logic [DW-1:0] ref_mem [0:15];
    bit            ptr_b_m = 0;
    int            timeouts = 0;
    bit            abort_mode = 0;
    bit            end_req = 0;
    bit            mon_done = 0;

    // monitor-owned counters
    int            n_cmp = 0, n_err = 0;
    logic          prev_wri = 0, prev_en = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_di = '0;
    logic [DW-1:0] last_rd = '0;
    int            wri_len = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic int lat(logic we);
        return we ? LAT_W : LAT_R;
    endfunction

    function automatic op_t mk(logic we, int addr, int data);
        op_t o;
        o.we = we; o.addr = AW'(addr); o.data = DW'(data);
        return o;
    endfunction

    // schedule one transfer after the previous ack at cycle 'prev'
    function automatic int push(bit side, op_t op, int prev);
        exp_t e;
        e.side = side; e.we = op.we; e.addr = op.addr;
        e.cyc  = prev + 1 + lat(op.we);
        if (op.we) begin
            ref_mem[op.addr] = op.data;
            e.data = op.data;
        end else begin
            e.data = ref_mem[op.addr];
        end
        q.push_back(e);
        ptr_b_m = !side;
        return e.cyc;
    endfunction

    // One arbitration round: A and/or B request once; quirk drops req_b and
    // scrambles B's fields one cycle after grant.
    task automatic issue(input bit ua, input op_t oa, input bit ub, input op_t ob, input bit quirk);
        int  e, t;
        bit  pa, pb, fb;
        @(negedge clk);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        e = cyc - 1;
        if (ua && ub) begin
            fb = ptr_b_m;
            e = push(fb, fb ? ob : oa, e);
            e = push(!fb, fb ? oa : ob, e);
        end else begin
            e = push(ub, ub ? ob : oa, e);
        end
        bus.we_a = oa.we; bus.addr_a = oa.addr; bus.wdata_a = oa.data; bus.req_a = ua;
        bus.we_b = ob.we; bus.addr_b = ob.addr; bus.wdata_b = ob.data; bus.req_b = ub;
        pa = ua; pb = ub; t = 0;
        while ((pa || pb) && t < BOUND) begin
            @(negedge clk);
            t++;
            if (quirk && t == 2) begin
                bus.req_b = 1'b0; bus.wdata_b = ~ob.data; bus.addr_b = ~ob.addr; bus.we_b = ~ob.we;
            end
            if (bus.ack_a) begin pa = 0; bus.req_a = 1'b0; end
            if (bus.ack_b) begin pb = 0; bus.req_b = 1'b0; end
        end
        if (pa || pb) begin
            timeouts++;
            $display("FAIL ack_timeout: got no ack expected ack by cycle %0d", e);
            bus.req_a = 1'b0; bus.req_b = 1'b0;
        end
    endtask

    // both requesters held high for n transfers
    task automatic held_both(input op_t oa, input op_t ob, input int n);
        int e, acks, t;
        bit s;
        @(negedge clk);
        e = cyc - 1;
        for (int i = 0; i < n; i++) begin
            s = ptr_b_m;
            e = push(s, s ? ob : oa, e);
        end
        bus.we_a = oa.we; bus.addr_a = oa.addr; bus.wdata_a = oa.data; bus.req_a = 1'b1;
        bus.we_b = ob.we; bus.addr_b = ob.addr; bus.wdata_b = ob.data; bus.req_b = 1'b1;
        acks = 0; t = 0;
        while (acks < n && t < n * BOUND) begin
            @(negedge clk);
            t++;
            if (bus.ack_a || bus.ack_b) acks++;
        end
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        if (acks < n) begin
            timeouts++;
            $display("FAIL held_timeout: got %0d acks expected %0d", acks, n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset_L = 1'b0;
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        ptr_b_m = 0;
    endtask

    // reset lands in the middle of a write pulse; that transfer is lost
    task automatic abort_write();
        int t;
        abort_mode = 1;
        @(negedge clk);
        bus.we_a = 1'b1; bus.addr_a = 4'd5; bus.wdata_a = 4'h3; bus.req_a = 1'b1;
        t = 0;
        while (!bus.mem_wri && t < BOUND) begin @(negedge clk); t++; end
        if (!bus.mem_wri) begin
            timeouts++;
            $display("FAIL wri_timeout: got mem_wri 0 expected 1");
        end
        #2 reset_L = 1'b0;
        bus.req_a = 1'b0;
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        ptr_b_m = 0;
        abort_mode = 0;
    endtask

    // monitor / scoreboard
    always @(negedge clk or negedge reset_L) begin
        exp_t e;
        if (!reset_L) begin
            #1;
            chk("rst_wri", bus.mem_wri, 0);
            chk("rst_en", bus.mem_en, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_ack", {bus.ack_a, bus.ack_b}, 0);
            chk("rst_rdata", bus.rdata, 0);
            chk("rst_addr", bus.mem_addr, 0);
            chk("rst_di", bus.mem_di, 0);
            prev_wri = 0; prev_en = 0; wri_len = 0; last_rd = '0;
        end else begin
            if (q.size() == 0 && !abort_mode) begin
                chk("idle_en", bus.mem_en, 0);
                chk("idle_wri", bus.mem_wri, 0);
                chk("idle_busy", bus.busy, 0);
            end
            if (bus.mem_wri) begin
                chk("wri_en", bus.mem_en, 1);
                if (!prev_wri) begin
                    wri_len = 0;
                    if (q.size() != 0) begin
                        chk("setup_en", prev_en, 1);
                        chk("setup_addr", prev_addr, q[0].addr);
                        chk("setup_di", prev_di, q[0].data);
                    end
                end
                wri_len++;
                if (q.size() != 0) begin
                    chk("wr_addr", bus.mem_addr, q[0].addr);
                    chk("wr_di", bus.mem_di, q[0].data);
                end
            end else if (prev_wri) begin
                chk("wp_width", wri_len, T_WP);
                if (q.size() != 0) begin
                    chk("hold_en", bus.mem_en, 1);
                    chk("hold_addr", bus.mem_addr, q[0].addr);
                    chk("hold_di", bus.mem_di, q[0].data);
                end
            end
            if (bus.ack_a || bus.ack_b) begin
                chk("ack_excl", bus.ack_a && bus.ack_b, 0);
                chk("ack_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("ack_side", bus.ack_b, e.side);
                    chk("ack_cycle", cyc, e.cyc);
                    if (e.we) begin
                        chk("rdata_hold", bus.rdata, last_rd);
                    end else begin
                        chk("rdata", bus.rdata, e.data);
                        last_rd = e.data;
                    end
                end
            end
            if (end_req && !mon_done) begin
                chk("queue_empty", q.size(), 0);
                chk("timeouts", timeouts, 0);
                mon_done = 1;
            end
            prev_wri = bus.mem_wri; prev_en = bus.mem_en;
            prev_addr = bus.mem_addr; prev_di = bus.mem_di;
        end
    end

    initial begin
        op_t na;
        int  m;
        na = mk(0, 0, 0);
        bus.req_a = 0; bus.we_a = 0; bus.addr_a = '0; bus.wdata_a = '0;
        bus.req_b = 0; bus.we_b = 0; bus.addr_b = '0; bus.wdata_b = '0;
        repeat (3) @(negedge clk);
        reset_L = 1'b1;
        repeat (3) @(negedge clk);

        issue(1, mk(1, 3, 'hA), 0, na, 0);          // write A
        issue(1, mk(0, 3, 0), 0, na, 0);            // read back A

        do_reset();
        held_both(mk(1, 1, 6), mk(1, 2, 9), 4);     // A,B,A,B

        abort_write();
        issue(1, mk(1, 5, 'hC), 0, na, 0);          // rewrite after abort
        issue(0, na, 1, mk(0, 5, 0), 0);

        for (int a = 0; a < 16; a++)
            issue(a[0], mk(1, a, $urandom_range(0, 15)), !a[0], mk(1, a, $urandom_range(0, 15)), 0);

        issue(0, na, 1, mk(0, 7, 0), 1);            // req_b dropped after grant
        issue(0, na, 1, mk(1, 9, 5), 1);            // wdata_b changed mid-write
        issue(1, mk(0, 9, 0), 0, na, 0);

        for (int i = 0; i < 30; i++) begin
            m = $urandom_range(0, 2);
            issue(m != 1, mk($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15)),
                  m != 0, mk($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15)), 0);
        end

        @(negedge clk);
        end_req = 1;
        for (int i = 0; i < 5 && !mon_done; i++) @(negedge clk);
        if (!mon_done) begin
            n_err++;
            $display("FAIL monitor_end: got no final check expected one");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
